// File: rtl/lsu_pkg.sv
// Shared types and constants for the LSU peripheral I/O slice.
// Access-size encoding, HEX reset pattern, base addresses and lane helpers.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  localparam logic [31:0] HEX_RESET = 32'h7F7F_7F7F;

  localparam logic [31:0] LEDR_BASE  = 32'h1000_0000;
  localparam logic [31:0] LEDG_BASE  = 32'h1000_1000;
  localparam logic [31:0] HEX30_BASE = 32'h1000_2000;
  localparam logic [31:0] HEX74_BASE = 32'h1000_3000;
  localparam logic [31:0] LCD_BASE   = 32'h1000_4000;
  localparam logic [31:0] SW_BASE    = 32'h1001_0000;

  localparam int NUM_OUT_REGS = 5;
  localparam int REG_LEDR     = 0;
  localparam int REG_LEDG     = 1;
  localparam int REG_HEX30    = 2;
  localparam int REG_HEX74    = 3;
  localparam int REG_LCD      = 4;

  function automatic logic access_legal(input size_e size, input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (size)
      SIZE_B:  ok = 1'b1;
      SIZE_H:  ok = ~off[0];
      SIZE_W:  ok = (off == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    logic [3:0] m;
    m = 4'b0000;
    case (size)
      SIZE_B:  m = 4'b0001 << off;
      SIZE_H:  m = 4'b0011 << off;
      SIZE_W:  m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_periph_io_if.sv
// LSU-side bus between the address decoder/EX-MEM stage and the peripheral register file.
interface lsu_periph_io_if;
  logic [31:0] i_addr;
  logic        i_st_en;
  logic        i_ld_en;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic [31:0] i_st_data;
  logic        i_addr_is_ledr;
  logic        i_addr_is_ledg;
  logic        i_addr_is_hex30;
  logic        i_addr_is_hex74;
  logic        i_addr_is_lcd;
  logic        i_addr_is_sw;
  logic [31:0] o_ld_data;
  logic        o_ld_valid;
  logic        o_access_err;

  modport master (
    output i_addr, i_st_en, i_ld_en, i_size, i_unsigned, i_st_data,
    output i_addr_is_ledr, i_addr_is_ledg, i_addr_is_hex30,
    output i_addr_is_hex74, i_addr_is_lcd, i_addr_is_sw,
    input  o_ld_data, o_ld_valid, o_access_err
  );

  modport slave (
    input  i_addr, i_st_en, i_ld_en, i_size, i_unsigned, i_st_data,
    input  i_addr_is_ledr, i_addr_is_ledg, i_addr_is_hex30,
    input  i_addr_is_hex74, i_addr_is_lcd, i_addr_is_sw,
    output o_ld_data, o_ld_valid, o_access_err
  );
endinterface

// File: rtl/lsu_periph_io_sw_input_sync.sv
// Switch input path: 2-flop synchroniser followed by a commit stage.
// Define SW_DEBOUNCE_EN to commit only after DEBOUNCE_CYCLES stable cycles.
module sw_input_sync #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_io_sw,
  output logic [31:0] o_sw_committed
);

  logic [31:0] r_sync1;
  logic [31:0] r_sync2;
  logic [31:0] r_committed;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_io_sw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [31:0]   r_cand;
  logic [CW-1:0] r_cnt;

  // Any differing bit restarts the shared window; commit lands on the edge the count reaches max.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cand      <= '0;
      r_cnt       <= '0;
      r_committed <= '0;
    end else if (r_sync2 != r_cand) begin
      r_cand <= r_sync2;
      r_cnt  <= '0;
    end else begin
      if (r_cnt != CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_cnt >= CNT_MAX - 1'b1) begin
        r_committed <= r_cand;
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_committed <= '0;
    end else begin
      r_committed <= r_sync2;
    end
  end
`endif

  assign o_sw_committed = r_committed;

endmodule

// File: rtl/lsu_periph_io.sv
// Memory-mapped peripheral register file on the LSU I/O side: lane stores, registered loads.
// Optional switch debounce enabled by defining SW_DEBOUNCE_EN.
module lsu_periph_io
  import lsu_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  lsu_periph_io_if.slave        bus,
  input  logic [31:0]           i_io_sw,
  output logic [31:0]           o_io_ledr,
  output logic [31:0]           o_io_ledg,
  output logic [31:0]           o_io_lcd,
  output logic [6:0]            o_io_hex0,
  output logic [6:0]            o_io_hex1,
  output logic [6:0]            o_io_hex2,
  output logic [6:0]            o_io_hex3,
  output logic [6:0]            o_io_hex4,
  output logic [6:0]            o_io_hex5,
  output logic [6:0]            o_io_hex6,
  output logic [6:0]            o_io_hex7
);

  logic [1:0]  w_off;
  size_e       w_size;
  logic        w_legal;
  logic [3:0]  w_lane_mask;
  logic [31:0] w_st_wdata;
  logic        w_st_fire;
  logic        w_ld_fire;
  logic [NUM_OUT_REGS-1:0] w_reg_sel;
  logic [31:0] w_out_regs [NUM_OUT_REGS];
  logic [31:0] w_sw_committed;
  logic [31:0] w_ld_src;
  logic [31:0] w_ld_shift;
  logic [31:0] w_ld_ext;
  logic        w_unused_addr_bits;

  logic [31:0] r_ld_data;
  logic        r_ld_valid;
  logic        r_access_err;

  assign w_off              = bus.i_addr[1:0];
  assign w_unused_addr_bits = ^bus.i_addr[31:2];
  assign w_size             = size_e'(bus.i_size);
  assign w_legal            = access_legal(w_size, w_off);
  assign w_lane_mask        = lane_mask(w_size, w_off);
  assign w_st_fire          = bus.i_st_en & w_legal;
  assign w_ld_fire          = bus.i_ld_en & ~bus.i_st_en;

  assign w_reg_sel[REG_LEDR]  = bus.i_addr_is_ledr;
  assign w_reg_sel[REG_LEDG]  = bus.i_addr_is_ledg;
  assign w_reg_sel[REG_HEX30] = bus.i_addr_is_hex30;
  assign w_reg_sel[REG_HEX74] = bus.i_addr_is_hex74;
  assign w_reg_sel[REG_LCD]   = bus.i_addr_is_lcd;

  // Replicate right-aligned store data across lanes so the lane mask alone selects the target bytes.
  always_comb begin
    w_st_wdata = bus.i_st_data;
    case (w_size)
      SIZE_B:  w_st_wdata = {4{bus.i_st_data[7:0]}};
      SIZE_H:  w_st_wdata = {2{bus.i_st_data[15:0]}};
      default: w_st_wdata = bus.i_st_data;
    endcase
  end

  for (genvar gi = 0; gi < NUM_OUT_REGS; gi++) begin : g_out_reg
    localparam logic [31:0] RST_VAL =
      ((gi == REG_HEX30) || (gi == REG_HEX74)) ? HEX_RESET : 32'h0;
    logic [31:0] r_val;

    always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
        r_val <= RST_VAL;
      end else if (w_st_fire && w_reg_sel[gi]) begin
        for (int b = 0; b < 4; b++) begin
          if (w_lane_mask[b]) begin
            r_val[b*8 +: 8] <= w_st_wdata[b*8 +: 8];
          end
        end
      end
    end

    assign w_out_regs[gi] = r_val;
  end

  sw_input_sync #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sw_input_sync (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_io_sw        (i_io_sw),
    .o_sw_committed (w_sw_committed)
  );

  always_comb begin
    w_ld_src = '0;
    if (bus.i_addr_is_ledr)       w_ld_src = w_out_regs[REG_LEDR];
    else if (bus.i_addr_is_ledg)  w_ld_src = w_out_regs[REG_LEDG];
    else if (bus.i_addr_is_hex30) w_ld_src = w_out_regs[REG_HEX30];
    else if (bus.i_addr_is_hex74) w_ld_src = w_out_regs[REG_HEX74];
    else if (bus.i_addr_is_lcd)   w_ld_src = w_out_regs[REG_LCD];
    else if (bus.i_addr_is_sw)    w_ld_src = w_sw_committed;
  end

  assign w_ld_shift = w_ld_src >> {w_off, 3'b000};

  always_comb begin
    w_ld_ext = '0;
    case (w_size)
      SIZE_B:  w_ld_ext = bus.i_unsigned ? {24'h0, w_ld_shift[7:0]}
                                         : {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      SIZE_H:  w_ld_ext = bus.i_unsigned ? {16'h0, w_ld_shift[15:0]}
                                         : {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      SIZE_W:  w_ld_ext = w_ld_shift;
      default: w_ld_ext = '0;
    endcase
  end

  // A load issued together with a store is dropped; ld_data holds its previous value.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_ld_data    <= '0;
      r_ld_valid   <= 1'b0;
      r_access_err <= 1'b0;
    end else begin
      r_ld_valid   <= w_ld_fire;
      r_access_err <= (bus.i_st_en | bus.i_ld_en) & ~w_legal;
      if (w_ld_fire) begin
        r_ld_data <= w_legal ? w_ld_ext : 32'h0;
      end
    end
  end

  assign bus.o_ld_data    = r_ld_data;
  assign bus.o_ld_valid   = r_ld_valid;
  assign bus.o_access_err = r_access_err;

  assign o_io_ledr = w_out_regs[REG_LEDR];
  assign o_io_ledg = w_out_regs[REG_LEDG];
  assign o_io_lcd  = w_out_regs[REG_LCD];
  assign o_io_hex0 = w_out_regs[REG_HEX30][6:0];
  assign o_io_hex1 = w_out_regs[REG_HEX30][14:8];
  assign o_io_hex2 = w_out_regs[REG_HEX30][22:16];
  assign o_io_hex3 = w_out_regs[REG_HEX30][30:24];
  assign o_io_hex4 = w_out_regs[REG_HEX74][6:0];
  assign o_io_hex5 = w_out_regs[REG_HEX74][14:8];
  assign o_io_hex6 = w_out_regs[REG_HEX74][22:16];
  assign o_io_hex7 = w_out_regs[REG_HEX74][30:24];

endmodule

// File: tb/tb_lsu_periph_io.sv
// Scoreboard bench for lsu_periph_io: stimulus pushes expected load data and error
// bits into queues, a monitor pops and compares one cycle after each strobe.
module tb_lsu_periph_io;
  import lsu_pkg::*;

  localparam int R_NONE = 0, R_LEDR = 1, R_LEDG = 2, R_HEX30 = 3;
  localparam int R_HEX74 = 4, R_LCD = 5, R_SW = 6;

  logic        clk;
  logic        rst_n;
  logic [31:0] io_sw;
  logic [31:0] io_ledr, io_ledg, io_lcd;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  lsu_periph_io_if bus();

  lsu_periph_io #(.DEBOUNCE_CYCLES(16)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .bus       (bus),
    .i_io_sw   (io_sw),
    .o_io_ledr (io_ledr),
    .o_io_ledg (io_ledg),
    .o_io_lcd  (io_lcd),
    .o_io_hex0 (hex0),
    .o_io_hex1 (hex1),
    .o_io_hex2 (hex2),
    .o_io_hex3 (hex3),
    .o_io_hex4 (hex4),
    .o_io_hex5 (hex5),
    .o_io_hex6 (hex6),
    .o_io_hex7 (hex7)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_loads = 0;
  logic        mon_en  = 1'b0;
  logic [31:0] ld_q [$];
  logic        err_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called at a negedge: present one cycle of bus activity, then wait for the next negedge.
  task automatic drive(input logic st, input logic ld, input logic [1:0] size,
                       input logic uns, input int region, input logic [1:0] off,
                       input logic [31:0] data, input logic exp_err);
    logic [31:0] base;
    case (region)
      R_LEDR:  base = LEDR_BASE;
      R_LEDG:  base = LEDG_BASE;
      R_HEX30: base = HEX30_BASE;
      R_HEX74: base = HEX74_BASE;
      R_LCD:   base = LCD_BASE;
      R_SW:    base = SW_BASE;
      default: base = 32'h0;
    endcase
    bus.i_addr          = base + {30'h0, off};
    bus.i_st_en         = st;
    bus.i_ld_en         = ld;
    bus.i_size          = size;
    bus.i_unsigned      = uns;
    bus.i_st_data       = data;
    bus.i_addr_is_ledr  = (region == R_LEDR);
    bus.i_addr_is_ledg  = (region == R_LEDG);
    bus.i_addr_is_hex30 = (region == R_HEX30);
    bus.i_addr_is_hex74 = (region == R_HEX74);
    bus.i_addr_is_lcd   = (region == R_LCD);
    bus.i_addr_is_sw    = (region == R_SW);
    err_q.push_back(exp_err);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 1'b0, R_NONE, 2'b00, 32'h0, 1'b0);
  endtask

  task automatic do_store(input int region, input logic [1:0] size, input logic [1:0] off,
                          input logic [31:0] data, input logic exp_err);
    drive(1'b1, 1'b0, size, 1'b0, region, off, data, exp_err);
  endtask

  task automatic do_load(input int region, input logic [1:0] size, input logic uns,
                         input logic [1:0] off, input logic [31:0] exp_data, input logic exp_err);
    ld_q.push_back(exp_data);
    drive(1'b0, 1'b1, size, uns, region, off, 32'h0, exp_err);
  endtask

  // Monitor: one cycle after each strobe, compare error pulse and any presented load.
  initial begin
    logic        e;
    logic [31:0] d;
    wait (mon_en);
    forever begin
      @(posedge clk);
      #1;
      if (err_q.size() > 0) begin
        e = err_q.pop_front();
        chk("access_err", {31'h0, bus.o_access_err}, {31'h0, e});
      end
      if (bus.o_ld_valid) begin
        n_loads++;
        if (ld_q.size() > 0) begin
          d = ld_q.pop_front();
          $display("load %0d: data=%h expected=%h", n_loads, bus.o_ld_data, d);
          chk("ld_data", bus.o_ld_data, d);
        end else begin
          n_total++;
          $display("FAIL unexpected_ld_valid: got data %h with no load outstanding", bus.o_ld_data);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    io_sw = 32'h0;
    bus.i_addr = '0; bus.i_st_en = 0; bus.i_ld_en = 0; bus.i_size = 0;
    bus.i_unsigned = 0; bus.i_st_data = '0;
    bus.i_addr_is_ledr = 0; bus.i_addr_is_ledg = 0; bus.i_addr_is_hex30 = 0;
    bus.i_addr_is_hex74 = 0; bus.i_addr_is_lcd = 0; bus.i_addr_is_sw = 0;
    repeat (3) @(negedge clk);

    chk("rst_ld_data", bus.o_ld_data, 32'h0);
    chk("rst_ld_valid", {31'h0, bus.o_ld_valid}, 32'h0);
    chk("rst_access_err", {31'h0, bus.o_access_err}, 32'h0);
    chk("rst_ledr", io_ledr, 32'h0);
    chk("rst_lcd", io_lcd, 32'h0);
    chk("rst_hex_all", {4'h0, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0},
        {4'h0, {8{7'h7F}}});

    rst_n  = 1'b1;
    mon_en = 1'b1;

    do_load(R_LEDR, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    do_load(R_HEX30, 2'b10, 1'b0, 2'd0, 32'h7F7F_7F7F, 1'b0);
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);

    do_store(R_LEDR, 2'b10, 2'd0, 32'hDEAD_BEEF, 1'b0);
    do_store(R_LEDR, 2'b00, 2'd2, 32'h0000_0012, 1'b0);
    chk("ledr_after_byte", io_ledr, 32'hDE12_BEEF);
    do_load(R_LEDR, 2'b10, 1'b0, 2'd0, 32'hDE12_BEEF, 1'b0);
    do_load(R_LEDR, 2'b00, 1'b0, 2'd3, 32'hFFFF_FFDE, 1'b0);
    do_load(R_LEDR, 2'b00, 1'b1, 2'd3, 32'h0000_00DE, 1'b0);

    do_store(R_HEX74, 2'b01, 2'd0, 32'h0000_4079, 1'b0);
    chk("hex4", {25'h0, hex4}, 32'h79);
    chk("hex5", {25'h0, hex5}, 32'h40);
    chk("hex6", {25'h0, hex6}, 32'h7F);
    chk("hex7", {25'h0, hex7}, 32'h7F);
    do_load(R_HEX74, 2'b01, 1'b0, 2'd0, 32'h0000_4079, 1'b0);
    do_load(R_HEX74, 2'b00, 1'b1, 2'd1, 32'h0000_0040, 1'b0);

    do_store(R_HEX30, 2'b00, 2'd0, 32'h0000_00FF, 1'b0);
    chk("hex0_bit7_hidden", {25'h0, hex0}, 32'h7F);
    do_load(R_HEX30, 2'b00, 1'b1, 2'd0, 32'h0000_00FF, 1'b0);

    do_store(R_LEDR, 2'b10, 2'd1, 32'h0000_0000, 1'b1);
    chk("ledr_after_bad_store", io_ledr, 32'hDE12_BEEF);
    do_load(R_LEDR, 2'b01, 1'b0, 2'd3, 32'h0, 1'b1);
    do_load(R_LEDR, 2'b11, 1'b0, 2'd0, 32'h0, 1'b1);
    do_load(R_LEDR, 2'b01, 1'b0, 2'd2, 32'hFFFF_DE12, 1'b0);

    do_load(R_NONE, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    do_store(R_SW, 2'b10, 2'd0, 32'hFFFF_FFFF, 1'b0);
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);

    drive(1'b1, 1'b1, 2'b10, 1'b0, R_LCD, 2'd0, 32'h0000_0001, 1'b0);
    chk("lcd_simul", io_lcd, 32'h1);

    do_store(R_LEDG, 2'b10, 2'd0, 32'hA5A5_0000, 1'b0);
    do_load(R_LEDG, 2'b10, 1'b0, 2'd0, 32'hA5A5_0000, 1'b0);
    do_load(R_LEDG, 2'b01, 1'b0, 2'd2, 32'hFFFF_A5A5, 1'b0);

`ifdef SW_DEBOUNCE_EN
    io_sw = 32'h5;
    repeat (7) idle();
    io_sw = 32'h0;
    idle();
    io_sw = 32'h5;
    repeat (12) idle();
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    repeat (30) idle();
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h5, 1'b0);
`else
    io_sw = 32'h5;
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h0, 1'b0);
    do_load(R_SW, 2'b10, 1'b0, 2'd0, 32'h5, 1'b0);
`endif

    repeat (4) idle();
    chk("ld_queue_drained", ld_q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lsu_periph_io.md
# lsu_periph_io

Memory-mapped peripheral register file on the load/store unit's I/O side, directly downstream of the LSU address decoder. Consumes the decoder's region flags (LEDR, LEDG, HEX30, HEX74, LCD, SW) plus the raw byte address. Performs byte/half/word stores into the output registers and registered loads with sign/zero extension. Synchronises, and optionally debounces, the switch inputs.

## Interface
- DEBOUNCE_CYCLES, default 16, stable-cycle count for switch commit; used only when SW_DEBOUNCE_EN is defined.
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, synchronous, active-low.
- i_addr  in  32  byte address from EX/MEM; only [1:0] is used here (lane select).
- i_st_en / i_ld_en  in  1 each  store / load strobe, single-cycle.
- i_size  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved.
- i_unsigned  in  1  load zero-extend when 1, sign-extend when 0.
- i_st_data  in  32  store data, right-aligned.
- i_addr_is_ledr, i_addr_is_ledg, i_addr_is_hex30, i_addr_is_hex74, i_addr_is_lcd, i_addr_is_sw  in  1 each  decoder region flags, at most one high.
- i_io_sw  in  32  raw asynchronous switch inputs.
- o_ld_data  out  32  load result, registered.
- o_ld_valid  out  1  high the cycle o_ld_data is valid.
- o_access_err  out  1  registered, one-cycle pulse on a misaligned or reserved-size access.
- o_io_ledr, o_io_ledg, o_io_lcd  out  32 each  output register contents.
- o_io_hex0 … o_io_hex7  out  7 each  seven-segment patterns, active-low.

## Operation
- Registers: LEDR, LEDG, LCD (32 b, reset 0); HEX30, HEX74 (32 b, reset 32'h7F7F_7F7F).
  - HEX30 byte n drives o_io_hex{n}[6:0].
  - HEX74 byte n drives o_io_hex{n+4}[6:0].
  - Bit 7 of each HEX byte is stored and read back but not driven out.
- Alignment:
  - Byte accesses are legal at any offset.
  - Half accesses are legal at offset 0 or 2.
  - Word accesses are legal at offset 0 only.
  - Size 11 is always illegal.
- Store (i_st_en, legal access, output-region flag high): write the lanes selected by size/offset from i_st_data[7:0], [15:0] or [31:0]; other lanes are unchanged.
- Illegal store: no register changes; o_access_err pulses.
- Stores to the SW region or to no flagged region: silently ignored, no error.
- Load (i_ld_en):
  - Select the source register by flag. SW reads the committed switch value.
  - Extract the addressed lane, then sign- or zero-extend to 32 b.
  - No flag high: returns 0.
  - Illegal load: returns 0 and pulses o_access_err.
- Simultaneous i_st_en and i_ld_en: the store executes, the load is dropped, and o_ld_valid stays low.
- Switch path: a 2-flop synchroniser on i_io_sw, then the commit stage (see Configuration). Committed value resets to 0.

## Timing
- Store: register updates at the first rising edge with i_st_en high; outputs reflect the new value the same cycle the register changes.
- Load latency is 1 cycle: o_ld_data and o_ld_valid are registered from the strobe cycle. o_ld_valid is low otherwise, and o_ld_data holds its last value.
- Store at cycle N followed by a load of the same address at N+1 returns the new value at N+2.
- o_access_err is asserted in cycle N+1 for an illegal strobe in cycle N.
- Reset values: o_ld_data 0, o_ld_valid 0, o_access_err 0, registers as listed under Operation.
  - Reset asserted mid-debounce clears the counter, candidate and committed value.
- Switch change to load-visible:
  - Without debounce: 2 synchroniser cycles + 1 commit cycle.
  - With debounce: synchroniser + DEBOUNCE_CYCLES + 1.

## Configuration
- SW_DEBOUNCE_EN defined:
  - One shared counter (width clog2(DEBOUNCE_CYCLES+1)) and a 32-b candidate register.
  - If the synchronised value differs from the candidate, load the candidate and clear the counter.
  - Otherwise count up, saturating at DEBOUNCE_CYCLES; on reaching it, copy the candidate to the committed value.
  - Any bit toggling restarts the window for all bits.
- SW_DEBOUNCE_EN undefined: the committed value is the synchronised value registered once. No counter or candidate is instantiated, and DEBOUNCE_CYCLES is ignored.

## Structure
- Shared package lsu_pkg:
  - size typedef (SIZE_B, SIZE_H, SIZE_W).
  - HEX reset constant 32'h7F7F_7F7F.
  - Peripheral base address constants, for the bench.
- One sub-module, sw_input_sync: synchroniser plus optional debounce, with the same clock/reset names, i_io_sw in and o_sw_committed out.
- Lane insert/extract logic stays in the top level.

## Test plan
- Reset then load LEDR, HEX30, SW (no switch activity) -> o_ld_data 0, 32'h7F7F7F7F, 0 respectively; all hex outputs 7'h7F.
- Store word 32'hDEADBEEF to LEDR, then store byte 8'h12 at offset 2 -> load word returns 32'hDE12BEEF; load byte at offset 3 signed returns 32'hFFFFFFDE; the same load unsigned returns 32'h000000DE.
- Half store 16'h4079 to HEX74 offset 0 -> o_io_hex4 7'h79, o_io_hex5 7'h40; o_io_hex6 and o_io_hex7 remain 7'h7F.
- Word store at offset 1 and half load at offset 3 -> o_access_err pulses one cycle each; register unchanged; load returns 0.
- With SW_DEBOUNCE_EN and DEBOUNCE_CYCLES=16, drive i_io_sw=32'h5 with one glitch at cycle 8 -> loaded SW stays 0 until the window is met after the glitch, then reads 32'h5. Without the macro, reads 32'h5 three cycles after the change.
- Simultaneous i_st_en and i_ld_en to LCD with 32'h1 -> LCD becomes 1; o_ld_valid stays low.
